// File: rtl/stream_xbar_pkg.sv
// -----------------------------------------------------------------------------
// stream_xbar_pkg
// Shared helpers for the stream crossbar return path:
//   idx_width / sel_width : index widths for requestor / responder ports
//                           (minimum width 1 so that single-port builds stay legal)
//   trk_flags_t           : per-responder tracker status (full / empty)
//   arb_state_e           : lock state of the round-robin arbiter
// -----------------------------------------------------------------------------
package stream_xbar_pkg;

  function automatic int unsigned idx_width(input int unsigned num_inp);
    return (num_inp > 1) ? $clog2(num_inp) : 1;
  endfunction

  function automatic int unsigned sel_width(input int unsigned num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

  // Status of one response tracker, derived from its fill level.
  typedef struct packed {
    logic full;
    logic empty;
  } trk_flags_t;

  // ARB_LOCKED: a request was offered but not yet accepted downstream, so the
  // arbiter must keep offering the same input until the handshake completes.
  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb_tree.sv
// -----------------------------------------------------------------------------
// rr_arb_tree
// Round-robin arbiter with valid/ready handshake on both sides.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (priority back to input 0)
//   req_i / gnt_o / data_i : NumIn requesting inputs
//   req_o / gnt_i / data_o : arbitrated output, idx_o = winning input
// Handshake: a transfer happens on req_o && gnt_i; gnt_o[k] is only raised
// for the selected, requesting input, so gnt_o never fires without req_i.
// With LockIn set, an offered but not yet accepted input stays selected
// until its handshake completes, keeping data_o/idx_o stable.
// Priority starts at input 0 and moves to the input after each winner.
// -----------------------------------------------------------------------------
module rr_arb_tree
  import stream_xbar_pkg::*;
#(
  parameter int unsigned NumIn     = 2,
  parameter type         DataType  = logic,
  parameter bit          AxiVldRdy = 1'b1,
  parameter bit          LockIn    = 1'b1,
  // derived, do not override
  parameter int unsigned IdxWidth  = idx_width(NumIn)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [NumIn-1:0]         req_i,
  output logic [NumIn-1:0]         gnt_o,
  input  DataType [NumIn-1:0]      data_i,
  output logic                     req_o,
  input  logic                     gnt_i,
  output DataType                  data_o,
  output logic [IdxWidth-1:0]      idx_o
);

  arb_state_e            state_q, state_d;
  logic [IdxWidth-1:0]   rr_q, rr_d;
  logic [IdxWidth-1:0]   lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0]   sel;
  logic                  found;
  int unsigned           cand;

  // First requesting input at or after the priority pointer, unless locked.
  always_comb begin
    sel   = rr_q;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      cand = (32'(rr_q) + k) % NumIn;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = IdxWidth'(cand);
      end
    end
    if (state_q == ARB_LOCKED) begin
      sel = lock_idx_q;
    end
  end

  assign req_o  = req_i[sel];
  assign data_o = data_i[sel];
  assign idx_o  = sel;

  always_comb begin
    gnt_o = '0;
    gnt_o[sel] = gnt_i && req_o && (AxiVldRdy || req_i[sel]);
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    case (state_q)
      ARB_FREE: begin
        if (LockIn && req_o && !gnt_i) begin
          state_d    = ARB_LOCKED;
          lock_idx_d = sel;
        end
      end
      ARB_LOCKED: begin
        if (!req_o || gnt_i) begin
          state_d = ARB_FREE;
        end
      end
      default: state_d = ARB_FREE;
    endcase
    if (req_o && gnt_i) begin
      rr_d = (sel == IdxWidth'(NumIn - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_FREE;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      state_q    <= ARB_FREE;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/spill_register.sv
// -----------------------------------------------------------------------------
// spill_register
// Two-entry register slice that cuts every combinational path between its
// sides while sustaining one transfer per cycle.
// Ports:
//   clk_i, rst_i (async, active-high)
//   valid_i / ready_o / data_i : upstream handshake
//   valid_o / ready_i / data_o : downstream handshake
// Entry A takes new data; B only catches A's content when the downstream
// side stalls while A is being drained.
// -----------------------------------------------------------------------------
module spill_register #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  logic a_full_q, a_full_d, b_full_q, b_full_d;
  T     a_data_q, b_data_q;
  logic a_fill, a_drain, b_fill, b_drain;

  assign a_fill  = valid_i && ready_o;
  assign a_drain = a_full_q && !b_full_q;
  assign b_fill  = a_drain && !ready_i;
  assign b_drain = b_full_q && ready_i;

  always_comb begin
    a_full_d = a_full_q;
    b_full_d = b_full_q;
    if (a_fill) begin
      a_full_d = 1'b1;
    end else if (a_drain) begin
      a_full_d = 1'b0;
    end
    if (b_fill) begin
      b_full_d = 1'b1;
    end else if (b_drain) begin
      b_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      if (a_fill) begin
        a_data_q <= data_i;
      end
      if (b_fill) begin
        b_data_q <= a_data_q;
      end
    end
  end

  assign valid_o = a_full_q || b_full_q;
  assign data_o  = b_full_q ? b_data_q : a_data_q;
  assign ready_o = !a_full_q || !b_full_q;

endmodule

// File: rtl/stream_xbar_rsp_tracker.sv
// -----------------------------------------------------------------------------
// stream_xbar_rsp_tracker
// Per-responder FIFO of requestor indices, in issue order.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync clear)
//   push_i / data_i  : record an issued transaction (ignored when full)
//   pop_i            : retire the head entry (ignored when empty)
//   head_o           : requestor index of the oldest outstanding transaction
//   count_o          : fill level, 0..Depth
// Pointers wrap modulo Depth; Depth need not be a power of two.
// -----------------------------------------------------------------------------
module stream_xbar_rsp_tracker #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned Width    = 1,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    head_o,
  output logic [CntWidth-1:0] count_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wptr_q, wptr_d;
  logic [PtrWidth-1:0] rptr_q, rptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                full, empty, push_ok, pop_ok;

  assign full    = (cnt_q == CntWidth'(Depth));
  assign empty   = (cnt_q == '0);
  // A full tracker refuses a push even when a pop frees a slot this cycle;
  // this keeps issue_ready free of any path from the response side.
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) begin
      wptr_d = (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int k = 0; k < Depth; k++) begin
        mem_q[k] <= '0;
      end
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push_ok) begin
        mem_q[wptr_q] <= data_i;
      end
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/stream_xbar_rsp.sv
// -----------------------------------------------------------------------------
// stream_xbar_rsp
// Return path of the stream crossbar. For every responder port it records,
// in issue order, which requestor each forwarded transaction came from, and
// routes that responder's in-order responses back to the originating
// requestor. Several responders aimed at one requestor are round-robin
// arbitrated; a grant offered but not accepted stays locked.
//
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (clear trackers + arbiters;
//   only with no valid responses pending)
//   issue_idx_i / issue_valid_i / issue_ready_o : per responder, from the
//       forward crossbar's output handshake
//   rsp_data_i / rsp_valid_i / rsp_ready_o      : per responder responses
//   data_o / sel_o / valid_o / ready_i          : per requestor routed
//       responses, sel_o = responder index
//   err_o, outstanding_o                        : only with the macro below
//
// Handshake: every channel transfers on valid && ready; a valid output keeps
// its data/sel stable until ready is seen.
//
// Build option STREAM_XBAR_RSP_ERR_EN: a response on an empty tracker is
// accepted and dropped and sets the sticky err_o bit; fill levels are
// exported on outstanding_o. Without it such responses stall.
// -----------------------------------------------------------------------------
module stream_xbar_rsp
  import stream_xbar_pkg::*;
#(
  parameter int unsigned NumInp      = 4,
  parameter int unsigned NumOut      = 4,
  parameter int unsigned DataWidth   = 1,
  parameter type         payload_t   = logic [DataWidth-1:0],
  parameter int unsigned MaxTxns     = 4,
  parameter bit          OutSpillReg = 1'b0,
  // derived, do not override
  parameter int unsigned IdxWidth    = idx_width(NumInp),
  parameter int unsigned SelWidth    = sel_width(NumOut),
  parameter int unsigned CntWidth    = $clog2(MaxTxns + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [NumOut-1:0][IdxWidth-1:0]   issue_idx_i,
  input  logic [NumOut-1:0]                 issue_valid_i,
  output logic [NumOut-1:0]                 issue_ready_o,
  input  payload_t [NumOut-1:0]             rsp_data_i,
  input  logic [NumOut-1:0]                 rsp_valid_i,
  output logic [NumOut-1:0]                 rsp_ready_o,
`ifdef STREAM_XBAR_RSP_ERR_EN
  output logic [NumOut-1:0]                 err_o,
  output logic [NumOut-1:0][CntWidth-1:0]   outstanding_o,
`endif
  output payload_t [NumInp-1:0]             data_o,
  output logic [NumInp-1:0][SelWidth-1:0]   sel_o,
  output logic [NumInp-1:0]                 valid_o,
  input  logic [NumInp-1:0]                 ready_i
);

  typedef struct packed {
    payload_t              data;
    logic [SelWidth-1:0]   sel;
  } route_t;

  logic [NumOut-1:0][IdxWidth-1:0]  head;
  logic [NumOut-1:0][CntWidth-1:0]  count;
  trk_flags_t                       flags [NumOut];
  logic [NumOut-1:0]                pop;
  logic [NumOut-1:0]                grant_any;
  logic [NumInp-1:0][NumOut-1:0]    req_arr;
  logic [NumInp-1:0][NumOut-1:0]    gnt_arr;

  // ---------------------------------------------------------------------------
  // Trackers
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < NumOut; j++) begin : g_trk
    stream_xbar_rsp_tracker #(
      .Depth    (MaxTxns),
      .Width    (IdxWidth),
      .CntWidth (CntWidth)
    ) u_trk (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (issue_valid_i[j]),
      .data_i  (issue_idx_i[j]),
      .pop_i   (pop[j]),
      .head_o  (head[j]),
      .count_o (count[j])
    );
  end

  always_comb begin
    for (int j = 0; j < NumOut; j++) begin
      flags[j].empty   = (count[j] == '0);
      flags[j].full    = (count[j] == CntWidth'(MaxTxns));
      issue_ready_o[j] = !flags[j].full;
    end
  end

  // ---------------------------------------------------------------------------
  // Request matrix: responder j asks only the arbiter of its head requestor.
  // The head is the registered FIFO output, so an entry pushed this cycle
  // cannot route a response before the next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      for (int j = 0; j < NumOut; j++) begin
        req_arr[i][j] = rsp_valid_i[j] && !flags[j].empty &&
                        (head[j] == IdxWidth'(i));
      end
    end
  end

  // At most one arbiter sees a request from j, so OR-ing is exact.
  always_comb begin
    grant_any = '0;
    for (int i = 0; i < NumInp; i++) begin
      grant_any = grant_any | gnt_arr[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Ready / pop, with optional drop of unexpected responses
  // ---------------------------------------------------------------------------
`ifdef STREAM_XBAR_RSP_ERR_EN
  logic [NumOut-1:0] drop;
  logic [NumOut-1:0] err_q, err_d;

  always_comb begin
    for (int j = 0; j < NumOut; j++) begin
      drop[j] = rsp_valid_i[j] && flags[j].empty;
    end
    err_d = err_q | drop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= '0;
    end else if (flush_i) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign rsp_ready_o   = grant_any | drop;
  assign err_o         = err_q;
  assign outstanding_o = count;
`else
  assign rsp_ready_o = grant_any;
`endif

  // A grant implies a non-empty tracker, so dropped responses never pop.
  assign pop = rsp_valid_i & grant_any;

  // ---------------------------------------------------------------------------
  // Per-requestor arbitration and output stage
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NumInp; i++) begin : g_req
    logic                  arb_valid, arb_ready;
    payload_t              arb_data;
    logic [SelWidth-1:0]   arb_sel;
    route_t                arb_route, out_route;
    logic                  out_valid;

    rr_arb_tree #(
      .NumIn     (NumOut),
      .DataType  (payload_t),
      .AxiVldRdy (1'b1),
      .LockIn    (1'b1)
    ) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .req_i   (req_arr[i]),
      .gnt_o   (gnt_arr[i]),
      .data_i  (rsp_data_i),
      .req_o   (arb_valid),
      .gnt_i   (arb_ready),
      .data_o  (arb_data),
      .idx_o   (arb_sel)
    );

    assign arb_route.data = arb_data;
    assign arb_route.sel  = arb_sel;

    if (OutSpillReg) begin : g_spill
      spill_register #(
        .T (route_t)
      ) u_spill (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (arb_valid),
        .ready_o (arb_ready),
        .data_i  (arb_route),
        .valid_o (out_valid),
        .ready_i (ready_i[i]),
        .data_o  (out_route)
      );
    end else begin : g_comb
      assign out_valid = arb_valid;
      assign out_route = arb_route;
      assign arb_ready = ready_i[i];
    end

    // Idle outputs read as zero rather than whatever the arbiter points at.
    assign valid_o[i] = out_valid;
    assign data_o[i]  = out_valid ? out_route.data : '0;
    assign sel_o[i]   = out_valid ? out_route.sel : '0;
  end

endmodule
